// File: rtl/detector_stream_arbiter.sv
// Round-robin arbiter feeding one shared serial 1101 detector.
// Each granted word is shifted MSB-first and its hit count is returned as {id, count}.
module detector_stream_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int IDW   = 2,
  parameter int CNTW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              det_in,
  output logic              det_clr_n,
  input  logic              det_hit,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [CNTW-1:0]   resp_count,
  input  logic              resp_ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE, CLEAR, SHIFT, RESP
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] sh_q;
  logic [CNTW-1:0]  bit_q;
  logic [CNTW-1:0]  hit_q;
  logic [CNTW-1:0]  cnt_q;

  logic [IDW-1:0]   pick_d;
  logic             found_d;
  logic [CNTW-1:0]  hit_d;

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    int idx;
    pick_d  = '0;
    found_d = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found_d && req_valid[idx]) begin
        found_d = 1'b1;
        pick_d  = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && state_q == IDLE && found_d)
      req_ready[pick_d] = 1'b1;
  end

  assign hit_d      = hit_q + CNTW'(det_hit);
  assign det_in     = (state_q == SHIFT) & sh_q[WIDTH-1];
  assign det_clr_n  = rst & (state_q != CLEAR);
  assign resp_valid = (state_q == RESP);
  assign resp_id    = id_q;
  assign resp_count = cnt_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ-1);
      id_q    <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      hit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            sh_q    <= req_data[int'(pick_d)*WIDTH +: WIDTH];
            id_q    <= pick_d;
            last_q  <= pick_d;
            hit_q   <= '0;
            bit_q   <= '0;
            state_q <= CLEAR;
          end
        end
        CLEAR: state_q <= SHIFT;
        SHIFT: begin
          sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
          hit_q <= hit_d;
          bit_q <= bit_q + CNTW'(1);
          // Include a hit on the final bit in the reported count.
          if (bit_q == CNTW'(WIDTH-1)) begin
            cnt_q   <= hit_d;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_ready)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detector_stream_arbiter.sv
// Scoreboard bench for detector_stream_arbiter with a behavioural
// 1101 non-overlapping detector attached to the det_* pins.
module tb_detector_stream_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;
  localparam int CNTW  = 5;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  det_in;
  logic                  det_clr_n;
  logic                  det_hit;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [CNTW-1:0]       resp_count;
  logic                  resp_ready = 1'b1;
  logic                  busy;

  detector_stream_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .det_in(det_in), .det_clr_n(det_clr_n), .det_hit(det_hit),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_count(resp_count),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // 1101 non-overlapping Mealy detector, cleared by det_clr_n.
  logic [1:0] ds;
  always @(posedge clk or negedge det_clr_n) begin
    if (!det_clr_n) ds <= 2'd0;
    else begin
      case (ds)
        2'd0: ds <= det_in ? 2'd1 : 2'd0;
        2'd1: ds <= det_in ? 2'd2 : 2'd0;
        2'd2: ds <= det_in ? 2'd2 : 2'd3;
        default: ds <= 2'd0;
      endcase
    end
  end
  assign det_hit = (ds == 2'd3) && det_in;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   acc_cyc = 0;
  logic rv_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int cnt);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops one expectation per response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid && !rv_prev) rise_cyc = cyc;
    rv_prev = rst && resp_valid;
    if (rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("resp_id", int'(resp_id), e.id);
        chk("resp_count", int'(resp_count), e.cnt);
      end
    end
    if (|req_ready) chk("ready_onehot", $countones(req_ready), 1);
  end

  function automatic logic [WIDTH-1:0] tbl(input int i);
    logic [WIDTH-1:0] t [NREQ];
    t[0] = 16'hDADD;
    t[1] = 16'hFFFF;
    t[2] = 16'hD000;
    t[3] = 16'h000D;
    return t[i];
  endfunction

  task automatic load_table();
    for (int i = 0; i < NREQ; i++)
      req_data[i*WIDTH +: WIDTH] = tbl(i);
  endtask

  task automatic send(input int id, input logic [WIDTH-1:0] w);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    req_data[id*WIDTH +: WIDTH] = w;
    req_valid[id] = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!ok) chk("grant_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic multi(input logic [NREQ-1:0] mask, input int n);
    int got;
    got = 0;
    @(posedge clk); #1;
    req_valid = mask;
    for (int k = 0; k < 1000 && got < n; k++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) got++;
    end
    if (got < n) chk("multi_timeout", got, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDW-1:0]  hid;
    logic [CNTW-1:0] hcnt;
    bit ok;

    // Reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_det_in", int'(det_in), 0);
    chk("rst_det_clr_n", int'(det_clr_n), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_count", int'(resp_count), 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rel_det_clr_n", int'(det_clr_n), 1);

    // Single words and latency
    push(1, 3);
    send(1, 16'hDADD);
    drain();
    chk("latency", rise_cyc - acc_cyc, WIDTH + 2);
    push(0, 0); send(0, 16'hFFFF); drain();
    push(2, 0); send(2, 16'h0000); drain();
    push(3, 1); send(3, 16'hD000); drain();
    push(1, 1); send(1, 16'h000D); drain();

    // Back-pressure hold in RESP
    resp_ready = 1'b0;
    push(2, 3);
    send(2, 16'hDADD);
    @(posedge clk); #1 req_valid[0] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; break; end
    end
    if (!ok) chk("resp_timeout", 0, 1);
    hid  = resp_id;
    hcnt = resp_count;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_id", int'(resp_id), int'(hid));
      chk("hold_count", int'(resp_count), int'(hcnt));
      chk("hold_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    resp_ready = 1'b1;
    drain();

    // All four requesters continuously valid
    do_reset();
    load_table();
    push(0, 3); push(1, 0); push(2, 1); push(3, 1); push(0, 3);
    multi(4'hF, 5);
    drain();

    // Requesters 0 and 2 only
    do_reset();
    load_table();
    push(0, 3); push(2, 1); push(0, 3); push(2, 1);
    multi(4'h5, 4);
    drain();

    // Reset mid-shift at bit 7
    send(1, 16'hDADD);
    repeat (8) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_resp_valid", int'(resp_valid), 0);
    chk("midrst_det_clr_n", int'(det_clr_n), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    load_table();
    push(0, 3); push(2, 1);
    multi(4'h5, 2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
